// File: rtl/jump_target_gen_pkg.sv
// Shared definitions for jump/branch target generation: mode encodings and
// small decode helpers used by both the instruction decoder and the target generator.
package jump_target_gen_pkg;

    typedef logic [1:0] jt_mode_t;

    localparam jt_mode_t MODE_J      = 2'b00;
    localparam jt_mode_t MODE_BRANCH = 2'b01;
    localparam jt_mode_t MODE_JR     = 2'b10;
    localparam jt_mode_t MODE_SEQ    = 2'b11;

    // True for modes whose final target is formed relative to PC+4.
    function automatic logic mode_is_pc_relative(input jt_mode_t mode);
        logic rel;
        case (mode)
            MODE_BRANCH: rel = 1'b1;
            MODE_SEQ:    rel = 1'b1;
            MODE_J:      rel = 1'b0;
            MODE_JR:     rel = 1'b0;
            default:     rel = 1'b0;
        endcase
        return rel;
    endfunction

endpackage

// File: rtl/jump_target_gen_target_stage.sv
// Generic valid/ready pipeline register with synchronous flush; holds its
// payload while the downstream consumer stalls.
module target_stage
    import jump_target_gen_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Payload only loads on a real transfer so a stalled result never changes.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/jump_target_gen.sv
// Two-stage jump/branch target generator: S1 forms the mode-specific offset,
// S2 forms the final target and alignment flag.
module jump_target_gen
    import jump_target_gen_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 26,
    parameter int BR_W   = 16,
    parameter int SHIFT  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [1:0]        mode_i,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic [IMM_W-1:0]  imm_i,
    input  logic [ADDR_W-1:0] rs_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] target_o,
    output logic [1:0]        mode_o,
    output logic              misalign_o
);

    localparam int S1_W = 2 * ADDR_W + 2;
    localparam int S2_W = ADDR_W + 3;

    // J keeps the PC region bits above the shifted immediate.
    localparam logic [ADDR_W-1:0] J_HI_MASK  = ~ADDR_W'((64'd1 << (IMM_W + SHIFT)) - 64'd1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << SHIFT) - 64'd1);

    logic [ADDR_W-1:0] imm_zext;
    logic [ADDR_W-1:0] br_sext;
    logic [ADDR_W-1:0] offset_d;
    logic [S1_W-1:0]   s1_in_data;
    logic [S1_W-1:0]   s1_data_q;
    logic              s1_valid_q;
    logic              s1_in_valid;
    logic              s2_in_ready;

    jt_mode_t          s1_mode;
    logic [ADDR_W-1:0] s1_pc;
    logic [ADDR_W-1:0] s1_offset;
    logic [ADDR_W-1:0] target_d;
    logic              misalign_d;
    logic [S2_W-1:0]   s2_in_data;
    logic [S2_W-1:0]   s2_data_q;

    assign imm_zext    = ADDR_W'(imm_i);
    assign br_sext     = {{(ADDR_W - BR_W){imm_i[BR_W-1]}}, imm_i[BR_W-1:0]};
    assign s1_in_valid = in_valid_i && !flush_i;

    // S1 offset selection per mode.
    always_comb begin
        offset_d = '0;
        case (jt_mode_t'(mode_i))
            MODE_J:      offset_d = (pc_plus4_i & J_HI_MASK) | (imm_zext << SHIFT);
            MODE_BRANCH: offset_d = br_sext << SHIFT;
            MODE_JR:     offset_d = rs_data_i;
            MODE_SEQ:    offset_d = '0;
            default:     offset_d = '0;
        endcase
    end

    assign s1_in_data = {mode_i, pc_plus4_i, offset_d};

    target_stage #(.W(S1_W)) u_s1 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (s1_in_valid),
        .in_ready_o  (in_ready_o),
        .in_data_i   (s1_in_data),
        .out_valid_o (s1_valid_q),
        .out_ready_i (s2_in_ready),
        .out_data_o  (s1_data_q)
    );

    assign s1_mode   = jt_mode_t'(s1_data_q[S1_W-1 -: 2]);
    assign s1_pc     = s1_data_q[2*ADDR_W-1 -: ADDR_W];
    assign s1_offset = s1_data_q[ADDR_W-1:0];

    // S2 target: PC-relative modes add PC+4 (SEQ has a zero offset), others pass through.
    always_comb begin
        target_d = s1_offset;
        if (mode_is_pc_relative(s1_mode)) begin
            target_d = s1_pc + s1_offset;
        end else begin
            target_d = s1_offset;
        end
    end

    assign misalign_d = |(target_d & ALIGN_MASK);
    assign s2_in_data = {misalign_d, s1_mode, target_d};

    target_stage #(.W(S2_W)) u_s2 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (s1_valid_q),
        .in_ready_o  (s2_in_ready),
        .in_data_i   (s2_in_data),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (s2_data_q)
    );

    assign misalign_o = s2_data_q[S2_W-1];
    assign mode_o     = s2_data_q[S2_W-2 -: 2];
    assign target_o   = s2_data_q[ADDR_W-1:0];

endmodule

// File: tb/tb_jump_target_gen.sv
// Directed self-checking bench for jump_target_gen: inputs change and outputs
// are sampled on the falling edge.
module tb_jump_target_gen;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  mode_i;
    logic [31:0] pc_plus4_i;
    logic [25:0] imm_i;
    logic [31:0] rs_data_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] target_o;
    logic [1:0]  mode_o;
    logic        misalign_o;

    int n_checks = 0;
    int n_errors = 0;

    jump_target_gen dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mode_i      (mode_i),
        .pc_plus4_i  (pc_plus4_i),
        .imm_i       (imm_i),
        .rs_data_i   (rs_data_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .target_o    (target_o),
        .mode_o      (mode_o),
        .misalign_o  (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] pc,
                         input logic [25:0] imm, input logic [31:0] rs);
        in_valid_i = v;
        mode_i     = m;
        pc_plus4_i = pc;
        imm_i      = imm;
        rs_data_i  = rs;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] t, input logic [1:0] m, input logic mis);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
        chk({tag, "_target"}, 64'(target_o), 64'(t));
        chk({tag, "_mode"}, 64'(mode_o), 64'(m));
        chk({tag, "_mis"}, 64'(misalign_o), 64'(mis));
    endtask

    // One request with out_ready high; result must appear exactly two edges after acceptance.
    task automatic send_one(input string tag, input logic [1:0] m, input logic [31:0] pc,
                            input logic [25:0] imm, input logic [31:0] rs,
                            input logic [31:0] exp_t, input logic exp_mis);
        @(negedge clk_i);
        drive(1'b1, m, pc, imm, rs);
        chk({tag, "_rdy"}, 64'(in_ready_o), 64'd1);
        @(negedge clk_i);
        drive(1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        chk({tag, "_lat1"}, 64'(out_valid_o), 64'd0);
        @(negedge clk_i);
        chk_out(tag, exp_t, m, exp_mis);
    endtask

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_target", 64'(target_o), 64'd0);
        chk("rst_mode", 64'(mode_o), 64'd0);
        chk("rst_mis", 64'(misalign_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd1);

        send_one("j",      2'b00, 32'h0040_0004, 26'h000_0100, 32'h0, 32'h0000_0400, 1'b0);
        send_one("j_hi",   2'b00, 32'hA000_0000, 26'h3FF_FFFF, 32'h0, 32'hAFFF_FFFC, 1'b0);
        send_one("br_neg", 2'b01, 32'h0000_1000, 26'h000_FFFF, 32'h0, 32'h0000_0FFC, 1'b0);
        send_one("br_wrap",2'b01, 32'hFFFF_FFFC, 26'h000_0001, 32'h0, 32'h0000_0000, 1'b0);
        send_one("br_pos", 2'b01, 32'h0000_2000, 26'h3FF_0010, 32'h0, 32'h0000_2040, 1'b0);
        send_one("jr_mis", 2'b10, 32'h0000_0040, 26'h000_0000, 32'h0000_1002, 32'h0000_1002, 1'b1);
        send_one("jr_al",  2'b10, 32'h0000_0040, 26'h3FF_FFFF, 32'h1234_5678, 32'h1234_5678, 1'b0);
        send_one("seq_mis",2'b11, 32'h0000_2002, 26'h3FF_FFFF, 32'hFFFF_FFFF, 32'h0000_2002, 1'b1);
        send_one("seq",    2'b11, 32'h0000_3004, 26'h000_0000, 32'h0, 32'h0000_3004, 1'b0);

        // Throughput: three back-to-back requests, one result per cycle.
        @(negedge clk_i); drive(1'b1, 2'b00, 32'h0, 26'h000_0010, 32'h0);
        @(negedge clk_i); drive(1'b1, 2'b11, 32'h0000_0500, 26'h0, 32'h0);
        chk("tp_rdy", 64'(in_ready_o), 64'd1);
        @(negedge clk_i); drive(1'b1, 2'b10, 32'h0, 26'h0, 32'h0000_0603);
        chk_out("tp0", 32'h0000_0040, 2'b00, 1'b0);
        @(negedge clk_i); drive(1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        chk_out("tp1", 32'h0000_0500, 2'b11, 1'b0);
        @(negedge clk_i);
        chk_out("tp2", 32'h0000_0603, 2'b10, 1'b1);
        @(negedge clk_i);
        chk("tp_empty", 64'(out_valid_o), 64'd0);

        // Backpressure: A, B fill both stages, C must wait until release.
        out_ready_i = 1'b0;
        drive(1'b1, 2'b00, 32'h0, 26'h000_0001, 32'h0);
        chk("bp_rdyA", 64'(in_ready_o), 64'd1);
        @(negedge clk_i);
        drive(1'b1, 2'b11, 32'h0000_0100, 26'h0, 32'h0);
        chk("bp_rdyB", 64'(in_ready_o), 64'd1);
        @(negedge clk_i);
        drive(1'b1, 2'b01, 32'h0000_0200, 26'h000_0002, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_full%0d", i), 64'(in_ready_o), 64'd0);
            chk_out($sformatf("bp_hold%0d", i), 32'h0000_0004, 2'b00, 1'b0);
            @(negedge clk_i);
        end
        out_ready_i = 1'b1;
        #1;
        chk("bp_release_rdy", 64'(in_ready_o), 64'd1);
        chk_out("bp_A", 32'h0000_0004, 2'b00, 1'b0);
        @(negedge clk_i);
        drive(1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        chk_out("bp_B", 32'h0000_0100, 2'b11, 1'b0);
        @(negedge clk_i);
        chk_out("bp_C", 32'h0000_0208, 2'b01, 1'b0);
        @(negedge clk_i);
        chk("bp_no_dup", 64'(out_valid_o), 64'd0);

        // Flush with both stages full and a new request presented.
        out_ready_i = 1'b0;
        drive(1'b1, 2'b00, 32'h0, 26'h000_0020, 32'h0);
        @(negedge clk_i);
        drive(1'b1, 2'b00, 32'h0, 26'h000_0030, 32'h0);
        @(negedge clk_i);
        chk("fl_pre_valid", 64'(out_valid_o), 64'd1);
        drive(1'b1, 2'b00, 32'h0, 26'h000_0040, 32'h0);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        chk("fl_ready", 64'(in_ready_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fl_empty%0d", i), 64'(out_valid_o), 64'd0);
            @(negedge clk_i);
        end
        send_one("post_fl", 2'b00, 32'h0, 26'h000_0050, 32'h0, 32'h0000_0140, 1'b0);

        // Reset while a result is being presented.
        out_ready_i = 1'b0;
        drive(1'b1, 2'b10, 32'h0, 26'h0, 32'h0000_0800);
        @(negedge clk_i);
        drive(1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        @(negedge clk_i);
        chk("mr_pre_valid", 64'(out_valid_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk("mr_async_valid", 64'(out_valid_o), 64'd0);
        chk("mr_async_target", 64'(target_o), 64'd0);
        @(negedge clk_i);
        rst_i       = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mr_empty%0d", i), 64'(out_valid_o), 64'd0);
            @(negedge clk_i);
        end
        send_one("post_rst", 2'b01, 32'h0000_0100, 26'h000_0004, 32'h0, 32'h0000_0110, 1'b0);

        @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jump_target_gen.md
JUMP_TARGET_GEN -- requirements
Module: jump_target_gen

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PC/target width.
REQ-002 The block SHALL have parameter IMM_W, default 26, meaning jump immediate width.
REQ-003 The block SHALL have parameter BR_W, default 16, meaning branch offset width, taken from imm_i[BR_W-1:0]; BR_W <= IMM_W.
REQ-004 The block SHALL have parameter SHIFT, default 2, meaning word-alignment left shift amount.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk_i  input  1  clock; all state updates on the rising edge.
REQ-007 rst_i  input  1  asynchronous, active-high reset.
REQ-008 in_valid_i  input  1  request valid.
REQ-009 in_ready_o  output  1  block accepts a request this cycle.
REQ-010 mode_i  input  2  00 J, 01 BRANCH, 10 JR, 11 SEQ.
REQ-011 pc_plus4_i  input  ADDR_W  PC+4 of the requesting instruction.
REQ-012 imm_i  input  IMM_W  instruction immediate field.
REQ-013 rs_data_i  input  ADDR_W  register operand for JR.
REQ-014 flush_i  input  1  discard all in-flight requests.
REQ-015 out_valid_o  output  1  result valid.
REQ-016 out_ready_i  input  1  consumer accepts a result.
REQ-017 target_o  output  ADDR_W  computed target address.
REQ-018 mode_o  output  2  mode of the presented result.
REQ-019 misalign_o  output  1  target low SHIFT bits nonzero.

Function
REQ-020 A request SHALL be accepted on a cycle with in_valid_i and in_ready_o both high and flush_i low.
REQ-021 Two registered stages S1, S2 SHALL hold requests; each has a valid bit.
REQ-022 S2 SHALL advance when !s2_valid or out_ready_i; S1 SHALL advance when S2 advances or !s1_valid.
REQ-023 in_ready_o SHALL equal !s1_valid or S1 advancing (combinational, no dependence on in_valid_i).
REQ-024 S1 SHALL register the offset: J {pc_plus4[ADDR_W-1:IMM_W+SHIFT], imm_i, SHIFT zeros}; BRANCH sign-extended imm_i[BR_W-1:0] shifted left SHIFT; JR rs_data_i; SEQ zero.
REQ-025 S2 SHALL register target: BRANCH pc_plus4 + offset modulo 2^ADDR_W; SEQ pc_plus4; J/JR offset unchanged.
REQ-026 misalign_o SHALL be 1 only when target_o[SHIFT-1:0] != 0 (reachable for JR and SEQ).
REQ-027 Latency SHALL be 2 cycles from acceptance to out_valid_o with out_ready_i held high; throughput 1/cycle.
REQ-028 With out_valid_o high and out_ready_i low, target_o, mode_o, misalign_o SHALL hold stable.
REQ-029 Both stages full and out_ready_i low SHALL force in_ready_o low; no request dropped or duplicated.
REQ-030 flush_i SHALL clear s1_valid and s2_valid on the next edge; a request presented in the flush cycle SHALL be dropped; out_valid_o low in the following cycle.
REQ-031 Results SHALL emerge in acceptance order.

Reset
REQ-032 rst_i high SHALL immediately clear s1_valid, s2_valid; out_valid_o 0, target_o 0, mode_o 00, misalign_o 0, in_ready_o 1 after reset release.
REQ-033 Reset mid-operation SHALL discard all in-flight requests with no output pulse.

Structure
REQ-034 Mode encodings (J, BRANCH, JR, SEQ) SHALL live in a shared package as localparams, reused by decoder and this block.
REQ-035 One sub-module, target_stage, SHALL implement a generic valid/ready register stage instanced twice.

Verification
REQ-036 J: pc_plus4 0x0040_0004, imm 0x000_0100 -> target 0x0000_0400, misalign 0, 2 cycles later.
REQ-037 BRANCH: pc_plus4 0x0000_1000, imm[15:0] 0xFFFF -> target 0x0000_0FFC.
REQ-038 Wrap: BRANCH pc_plus4 0xFFFF_FFFC, imm 0x0001 -> target 0x0000_0000.
REQ-039 JR: rs 0x0000_1002 -> target 0x0000_1002, misalign 1.
REQ-040 Backpressure: 3 back-to-back requests, out_ready_i low 4 cycles -> in_ready_o low after 2 accepted, outputs stable, all 3 delivered in order on release.
REQ-041 Flush with both stages full plus new request -> out_valid_o 0 next cycle, no stale result ever delivered.
